// File: rtl/joypad_pkg.sv
// Shared joypad definitions: button indices, register address and the
// row-select helper that builds the active-low line nibble.
package joypad_pkg;

    // Button bit positions within the raw/stable vectors
    localparam int unsigned BTN_RIGHT  = 0;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_UP     = 2;
    localparam int unsigned BTN_DOWN   = 3;
    localparam int unsigned BTN_A      = 4;
    localparam int unsigned BTN_B      = 5;
    localparam int unsigned BTN_SELECT = 6;
    localparam int unsigned BTN_START  = 7;

    localparam logic [15:0] JOYPAD_BASE_ADDR = 16'hFF00;

    // Reset value of the select field: neither row selected
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Active-low line nibble; sel[0]=0 exposes directions, sel[1]=0 exposes actions
    function automatic logic [3:0] joypad_line(input logic [1:0] sel, input logic [7:0] stable);
        return ~(({4{~sel[0]}} & stable[3:0]) | ({4{~sel[1]}} & stable[7:4]));
    endfunction

endpackage

// File: rtl/bus_if.sv
// Peripheral bus between the MMU and memory-mapped peripherals.
interface Bus_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        read_en;
    logic        write_en;

    modport Peripheral_side (
        input  addr,
        input  wdata,
        input  read_en,
        input  write_en,
        output rdata
    );

    modport Mmu_side (
        output addr,
        output wdata,
        output read_en,
        output write_en,
        input  rdata
    );
endinterface

// File: rtl/joypad_debounce.sv
// Per-button 2-flop synchroniser followed by a consecutive-cycle debouncer.
// stable flips only after the synchronised value has differed from it for
// DEBOUNCE_CYCLES consecutive cycles; rise flags a 0->1 flip on the coming edge.
module joypad_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYCLES - 1);

    logic       meta_q;
    logic       sync_q;
    logic       stable_q;
    logic       stable_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Two-stage synchroniser for the asynchronous raw line
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Count consecutive differing cycles; flip stable on the last one
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q == stable_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == CntMax) begin
            stable_d = sync_q;
            cnt_d    = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Debounce state register
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = stable_d & ~stable_q;

endmodule

// File: rtl/joypad_ctrl.sv
// Joypad register (P1/JOYP): debounced buttons, active-low row select,
// combinational read and a level interrupt on any selected-line fall.
// Optional feature macro: JOYPAD_WAKE_EN adds a one-cycle wake pulse output
// on any debounced press, independent of the row select.
module joypad_ctrl
    import joypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [15:0] JOYPAD_ADDR     = JOYPAD_BASE_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    Bus_if.Peripheral_side bus,
    input  logic [7:0] buttons,
    output logic       irq_req,
    input  logic       irq_ack
`ifdef JOYPAD_WAKE_EN
    ,
    output logic       wake
`endif
);

    logic [7:0] stable_vec;
    logic [7:0] rise_vec;
    logic [1:0] sel_q;
    logic [1:0] sel_d;
    logic [3:0] line;
    logic [3:0] line_q;
    logic       fall;
    logic       irq_q;
    logic       irq_d;
    logic       reg_hit_wr;
    logic       reg_hit_rd;

    for (genvar i = 0; i < 8; i++) begin : g_btn
        joypad_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (buttons[i]),
            .stable(stable_vec[i]),
            .rise  (rise_vec[i])
        );
    end

    assign reg_hit_wr = bus.write_en && (bus.addr == JOYPAD_ADDR);
    assign reg_hit_rd = bus.read_en && (bus.addr == JOYPAD_ADDR);

    assign line = joypad_line(sel_q, stable_vec);
    assign fall = |(line_q & ~line);

    // Select update from bus writes and interrupt set/clear (set wins)
    always_comb begin
        sel_d = sel_q;
        if (reg_hit_wr) begin
            sel_d = bus.wdata[5:4];
        end
        irq_d = irq_q;
        if (fall) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    // Select, previous line nibble and interrupt state
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q  <= SEL_NONE;
            line_q <= 4'hF;
            irq_q  <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            line_q <= line;
            irq_q  <= irq_d;
        end
    end

    // Combinational register read; unmapped or idle reads float high
    always_comb begin
        bus.rdata = 8'hFF;
        if (reg_hit_rd) begin
            bus.rdata = {2'b11, sel_q, line};
        end
    end

    assign irq_req = irq_q;

`ifdef JOYPAD_WAKE_EN
    logic wake_q;

    // Pulse for one cycle as any debounced button becomes pressed
    always_ff @(posedge clk) begin
        if (reset) begin
            wake_q <= 1'b0;
        end else begin
            wake_q <= |rise_vec;
        end
    end

    assign wake = wake_q;

    logic unused_bits;
    assign unused_bits = ^{bus.wdata[7:6], bus.wdata[3:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{bus.wdata[7:6], bus.wdata[3:0], rise_vec};
`endif

endmodule

// File: tb/tb_joypad_ctrl.sv
// Randomised scoreboard bench for joypad_ctrl with a window-based reference model.
module tb_joypad_ctrl;

    localparam int unsigned D = 4;
    localparam logic [15:0] A = 16'hFF00;

    typedef struct packed {
        logic [7:0] rdata;
        logic       irq;
        logic       wake;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] buttons = 8'h00;
    logic       irq_req;
    logic       irq_ack = 1'b0;
    logic       wake;

    Bus_if bus_i ();

    joypad_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .JOYPAD_ADDR    (A)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus_i),
        .buttons(buttons),
        .irq_req(irq_req),
        .irq_ack(irq_ack)
`ifdef JOYPAD_WAKE_EN
        ,
        .wake   (wake)
`endif
    );

`ifndef JOYPAD_WAKE_EN
    assign wake = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model state (register contents after the latest edge)
    logic [7:0] m_s1, m_s2, m_st;
    logic [1:0] m_sel;
    logic [3:0] m_lq;
    logic       m_irq, m_wake;
    logic [7:0] hist[$];
    // Inputs applied during the previous cycle
    logic [7:0]  p_btn = 8'h00;
    logic        p_we = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
    logic [15:0] p_addr = 16'h0;
    logic [7:0]  p_wd = 8'h0;

    // Line i is low when its button is pressed in any selected row
    function automatic logic [3:0] mline(input logic [1:0] sel, input logic [7:0] st);
        logic [3:0] l;
        for (int i = 0; i < 4; i++) begin
            l[i] = !((sel[0] == 1'b0 && st[i]) || (sel[1] == 1'b0 && st[i + 4]));
        end
        return l;
    endfunction

    // Advance the model across one clock edge
    task automatic model_edge();
        logic [3:0] ln;
        logic [7:0] nst;
        logic       fall, all_diff;
        if (p_rst) begin
            m_s1 = 0; m_s2 = 0; m_st = 0; m_sel = 2'b11; m_lq = 4'hF;
            m_irq = 0; m_wake = 0;
            hist.delete();
        end else begin
            ln   = mline(m_sel, m_st);
            fall = |(m_lq & ~ln);
            nst  = m_st;
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            if (hist.size() == D) begin
                for (int i = 0; i < 8; i++) begin
                    all_diff = 1'b1;
                    foreach (hist[j]) if (hist[j][i] == m_st[i]) all_diff = 1'b0;
                    if (all_diff) nst[i] = ~m_st[i];
                end
            end
            m_wake = |(nst & ~m_st);
            if (fall) m_irq = 1'b1;
            else if (p_ack) m_irq = 1'b0;
            m_lq = ln;
            if (p_we && p_addr == A) m_sel = p_wd[5:4];
            m_st = nst;
            m_s2 = m_s1;
            m_s1 = p_btn;
        end
    endtask

    // One clock: model follows the edge, then new inputs are driven and expectations queued
    task automatic cycle(input logic [7:0] btn, input logic we, input logic re,
                         input logic [15:0] addr, input logic [7:0] wd,
                         input logic ack, input logic rst);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        buttons = btn; bus_i.write_en = we; bus_i.read_en = re; bus_i.addr = addr;
        bus_i.wdata = wd; irq_ack = ack; reset = rst;
        p_btn = btn; p_we = we; p_addr = addr; p_wd = wd; p_ack = ack; p_rst = rst;
        e.rdata = (re && addr == A) ? {2'b11, m_sel, mline(m_sel, m_st)} : 8'hFF;
        e.irq   = m_irq;
`ifdef JOYPAD_WAKE_EN
        e.wake  = m_wake;
`else
        e.wake  = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [7:0] btn, input int n);
        for (int i = 0; i < n; i++) cycle(btn, 1'b0, 1'b1, A, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic dcheck(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    // Monitor: compare DUT outputs with the queued expectation each cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus_i.rdata !== e.rdata || irq_req !== e.irq || wake !== e.wake) begin
                errors++;
                $display("FAIL scoreboard @%0t: rdata=%02h irq=%0b wake=%0b expected rdata=%02h irq=%0b wake=%0b",
                         $time, bus_i.rdata, irq_req, wake, e.rdata, e.irq, e.wake);
            end
        end
    end

    initial begin
        int lat;
        logic [7:0] btn;
        bus_i.addr = A; bus_i.wdata = 8'h00; bus_i.read_en = 1'b0; bus_i.write_en = 1'b0;

        // Reset state and unmapped read
        cycle(8'h00, 1'b0, 1'b1, A, 8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1, A, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        dcheck("reset_read", bus_i.rdata, 8'hFF);
        dcheck("reset_irq", {7'd0, irq_req}, 8'h00);
        cycle(8'h00, 1'b0, 1'b1, 16'hFF01, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        dcheck("read_ff01", bus_i.rdata, 8'hFF);

        // Directions selected, press right: irq latency and read value
        cycle(8'h00, 1'b1, 1'b1, A, 8'h20, 1'b0, 1'b0);
        idle(8'h00, 8);
        cycle(8'h01, 1'b0, 1'b1, A, 8'h00, 1'b0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(8'h01, 1'b0, 1'b1, A, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            if (irq_req === 1'b1) begin
                lat = k;
                break;
            end
        end
        dcheck("irq_latency", 8'(lat), 8'(2 + D + 1));
        dcheck("read_right", bus_i.rdata, 8'hEE);
        cycle(8'h01, 1'b0, 1'b1, A, 8'h00, 1'b1, 1'b0);
        cycle(8'h01, 1'b0, 1'b1, A, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        dcheck("ack_clears", {7'd0, irq_req}, 8'h00);

        // Release, then a 3-cycle glitch must be filtered
        idle(8'h00, 10);
        @(negedge clk);
        dcheck("released", bus_i.rdata, 8'hEF);
        idle(8'h01, 3);
        idle(8'h00, 10);
        @(negedge clk);
        dcheck("glitch_read", bus_i.rdata, 8'hEF);
        dcheck("glitch_irq", {7'd0, irq_req}, 8'h00);

        // Start held with no row selected, then expose the action row
        cycle(8'h80, 1'b1, 1'b1, A, 8'h30, 1'b0, 1'b0);
        idle(8'h80, 10);
        @(negedge clk);
        dcheck("start_hidden", bus_i.rdata, 8'hFF);
        dcheck("start_no_irq", {7'd0, irq_req}, 8'h00);
        cycle(8'h80, 1'b1, 1'b1, A, 8'h10, 1'b0, 1'b0);
        idle(8'h80, 2);
        @(negedge clk);
        dcheck("start_shown", bus_i.rdata, 8'hD7);
        dcheck("sel_write_irq", {7'd0, irq_req}, 8'h01);

        // Ack in the same cycle as a new fall: set wins
        cycle(8'h80, 1'b1, 1'b1, A, 8'h20, 1'b0, 1'b0);
        idle(8'h80, 2);
        cycle(8'h82, 1'b0, 1'b1, A, 8'h00, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) cycle(8'h82, 1'b0, 1'b1, A, 8'h00, k == 6, 1'b0);
        @(negedge clk);
        dcheck("set_wins", {7'd0, irq_req}, 8'h01);
        cycle(8'h82, 1'b0, 1'b1, A, 8'h00, 1'b1, 1'b0);
        cycle(8'h82, 1'b0, 1'b1, A, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        dcheck("ack_after_set", {7'd0, irq_req}, 8'h00);

        // Reset while A is mid-debounce; held buttons re-qualify afterwards
        cycle(8'h92, 1'b1, 1'b1, A, 8'h10, 1'b0, 1'b0);
        idle(8'h92, 3);
        cycle(8'h92, 1'b0, 1'b1, A, 8'h00, 1'b0, 1'b1);
        cycle(8'h92, 1'b0, 1'b1, A, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        dcheck("read_after_reset", bus_i.rdata, 8'hFF);
        cycle(8'h92, 1'b1, 1'b1, A, 8'h10, 1'b0, 1'b0);
        idle(8'h92, 4);
        @(negedge clk);
        dcheck("requal_pending", bus_i.rdata, 8'hDF);
        idle(8'h92, 1);
        @(negedge clk);
        dcheck("requal_done", bus_i.rdata, 8'hD6);

        // Randomised traffic
        btn = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ad;
            if ($urandom_range(7) == 0) btn = btn ^ (8'h01 << $urandom_range(7));
            ad = ($urandom_range(3) == 0) ? 16'($urandom) : A;
            cycle(btn, $urandom_range(5) == 0, $urandom_range(1) == 1, ad, 8'($urandom),
                  $urandom_range(4) == 0, $urandom_range(299) == 0);
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
